// File: rtl/fft_test_sys_nios2_gen2_0_cpu_debug_ocimem.sv
// Nios II debug OCI memory: one-deep JTAG request slot and a CPU Avalon-MM port sharing a single-port RAM.
// Build option OCIMEM_AUTOINC_EN: MonAReg steps after each JTAG write commit and each streaming read.
module fft_test_sys_nios2_gen2_0_cpu_debug_ocimem #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  input  logic [3:0]        byteenable,
  output logic [31:0]       readdata,
  output logic              waitrequest,
  output logic [31:0]       MonDReg,
  output logic [ADDR_W-1:0] MonAReg,
  output logic              jtag_overrun
);
  localparam int DEPTH = 1 << ADDR_W;

`ifdef OCIMEM_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, JRD, JWR, CRD} state_t;

  state_t            state_q, state_d;
  logic              pend_valid_q, pend_valid_d;
  logic              pend_wr_q, pend_wr_d;
  logic              pend_inc_q, pend_inc_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic [31:0]       pend_data_q, pend_data_d;
  logic [31:0]       mon_d_q, mon_d_d;
  logic [ADDR_W-1:0] mon_a_q, mon_a_d;
  logic [31:0]       readdata_q, readdata_d;
  logic              overrun_q, overrun_d;

  logic [31:0]       mem [DEPTH];
  logic [31:0]       ram_rdata_q;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [3:0]        ram_be;
  logic [31:0]       ram_wdata;

  logic              new_req, new_wr, new_inc;
  logic [ADDR_W-1:0] new_addr, jdo_addr;
  logic              serving, launch;
  logic              jdo_unused;

  assign jdo_unused = ^jdo;

  // Decode the strobes into a single request; only one strobe is expected per cycle.
  always_comb begin
    jdo_addr = jdo[ADDR_W+25:26];
    new_req  = 1'b0;
    new_wr   = 1'b0;
    new_inc  = 1'b0;
    new_addr = mon_a_q;
    if (take_action_ocimem_a) begin
      new_req  = jdo[34];
      new_addr = jdo_addr;
    end else if (take_action_ocimem_b) begin
      new_req = 1'b1;
      new_wr  = 1'b1;
      new_inc = 1'b1;
    end else if (take_no_action_ocimem_a) begin
      new_req = 1'b1;
      new_inc = 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    pend_valid_d = pend_valid_q;
    pend_wr_d    = pend_wr_q;
    pend_inc_d   = pend_inc_q;
    pend_addr_d  = pend_addr_q;
    pend_data_d  = pend_data_q;
    mon_d_d      = mon_d_q;
    mon_a_d      = mon_a_q;
    readdata_d   = readdata_q;
    overrun_d    = overrun_q;
    ram_addr     = address;
    ram_we       = 1'b0;
    ram_be       = byteenable;
    ram_wdata    = writedata;
    waitrequest  = read | write;
    serving      = (state_q == JRD) || (state_q == JWR);
    // A request replaced in this very cycle is launched next cycle with its new contents.
    launch       = (state_q == IDLE) && pend_valid_q && !new_req;

    case (state_q)
      IDLE: begin
        if (pend_valid_q) begin
          ram_addr = pend_addr_q;
          if (launch) state_d = pend_wr_q ? JWR : JRD;
        end else if (read) begin
          state_d = CRD;
        end else if (write) begin
          ram_we      = 1'b1;
          waitrequest = 1'b0;
        end
      end
      JRD: begin
        mon_d_d      = ram_rdata_q;
        pend_valid_d = 1'b0;
        if (AUTOINC && pend_inc_q) mon_a_d = pend_addr_q + ADDR_W'(1);
        state_d      = IDLE;
      end
      JWR: begin
        ram_addr     = pend_addr_q;
        ram_we       = 1'b1;
        ram_be       = 4'hF;
        ram_wdata    = pend_data_q;
        pend_valid_d = 1'b0;
        if (AUTOINC && pend_inc_q) mon_a_d = pend_addr_q + ADDR_W'(1);
        state_d      = IDLE;
      end
      CRD: begin
        readdata_d = ram_rdata_q;
        if (read) waitrequest = 1'b0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (new_req) begin
      if (pend_valid_q && !serving) overrun_d = 1'b1;
      pend_valid_d = 1'b1;
      pend_wr_d    = new_wr;
      pend_inc_d   = new_inc;
      pend_addr_d  = new_addr;
      pend_data_d  = jdo[34:3];
    end
    if (take_action_ocimem_a) mon_a_d = jdo_addr;
  end

  // The read path is transparent during CRD so data arrives with waitrequest low.
  assign readdata     = (state_q == CRD) ? ram_rdata_q : readdata_q;
  assign MonDReg      = mon_d_q;
  assign MonAReg      = mon_a_q;
  assign jtag_overrun = overrun_q;

  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (ram_be[i]) mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
      end
    end
    ram_rdata_q <= mem[ram_addr];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      pend_valid_q <= 1'b0;
      pend_wr_q    <= 1'b0;
      pend_inc_q   <= 1'b0;
      pend_addr_q  <= '0;
      pend_data_q  <= '0;
      mon_d_q      <= '0;
      mon_a_q      <= '0;
      readdata_q   <= '0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_valid_q <= pend_valid_d;
      pend_wr_q    <= pend_wr_d;
      pend_inc_q   <= pend_inc_d;
      pend_addr_q  <= pend_addr_d;
      pend_data_q  <= pend_data_d;
      mon_d_q      <= mon_d_d;
      mon_a_q      <= mon_a_d;
      readdata_q   <= readdata_d;
      overrun_q    <= overrun_d;
    end
  end
endmodule

// File: tb/tb_fft_test_sys_nios2_gen2_0_cpu_debug_ocimem.sv
// Scoreboard bench for the debug OCI memory: expected CPU/JTAG read data is queued at issue
// and popped by a monitor when the DUT presents it; a word-array model tracks RAM and MonAReg.
module tb_fft_test_sys_nios2_gen2_0_cpu_debug_ocimem;

`ifdef OCIMEM_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [37:0] jdo;
  logic        take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b;
  logic [7:0]  address;
  logic        read, write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;
  logic        waitrequest;
  logic [31:0] MonDReg;
  logic [7:0]  MonAReg;
  logic        jtag_overrun;

  fft_test_sys_nios2_gen2_0_cpu_debug_ocimem #(.ADDR_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .jdo(jdo),
    .take_action_ocimem_a(take_action_ocimem_a),
    .take_no_action_ocimem_a(take_no_action_ocimem_a),
    .take_action_ocimem_b(take_action_ocimem_b),
    .address(address), .read(read), .write(write), .writedata(writedata),
    .byteenable(byteenable), .readdata(readdata), .waitrequest(waitrequest),
    .MonDReg(MonDReg), .MonAReg(MonAReg), .jtag_overrun(jtag_overrun)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] data; int due; } jtag_exp_t;

  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [31:0] mem_model [256];
  logic [7:0]  mon_a = 8'h00;
  logic [31:0] cpu_exp [$];
  jtag_exp_t   jtag_exp [$];
  jtag_exp_t   mon_item;
  logic [31:0] cpu_item;
  logic [7:0]  a;
  logic [31:0] d, d1, d2;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Monitor: CPU read data on handshake, JTAG read data on its due cycle.
  always @(negedge clk) begin
    if (reset_n && read && !waitrequest) begin
      if (cpu_exp.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL cpu_rd_extra: got 0x%08h with no read outstanding", readdata);
      end else begin
        cpu_item = cpu_exp.pop_front();
        checkOutput("cpu_readdata", readdata, cpu_item);
      end
    end
    if (jtag_exp.size() > 0 && cyc >= jtag_exp[0].due) begin
      mon_item = jtag_exp.pop_front();
      checkOutput("MonDReg", MonDReg, mon_item.data);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic ta, input logic tna, input logic tb, input logic [37:0] j);
    take_action_ocimem_a    = ta;
    take_no_action_ocimem_a = tna;
    take_action_ocimem_b    = tb;
    jdo                     = j;
    step();
    take_action_ocimem_a    = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    take_action_ocimem_b    = 1'b0;
    jdo                     = {6'($urandom), $urandom};
  endtask

  function automatic logic [37:0] jdoLoad(input logic [7:0] addr, input logic rd);
    return {3'($urandom), rd, addr, 26'($urandom)};
  endfunction

  function automatic logic [37:0] jdoData(input logic [31:0] data);
    return {3'($urandom), data, 3'($urandom)};
  endfunction

  task automatic jtagLoad(input logic [7:0] addr, input logic rd);
    mon_a = addr;
    if (rd) jtag_exp.push_back('{mem_model[addr], cyc + 3});
    applyStimulus(1'b1, 1'b0, 1'b0, jdoLoad(addr, rd));
    repeat (3) step();
  endtask

  task automatic jtagWrite(input logic [31:0] data);
    mem_model[mon_a] = data;
    if (AUTOINC) mon_a = mon_a + 8'd1;
    applyStimulus(1'b0, 1'b0, 1'b1, jdoData(data));
    repeat (3) step();
  endtask

  task automatic jtagStream();
    jtag_exp.push_back('{mem_model[mon_a], cyc + 3});
    if (AUTOINC) mon_a = mon_a + 8'd1;
    applyStimulus(1'b0, 1'b1, 1'b0, {6'($urandom), $urandom});
    repeat (3) step();
  endtask

  task automatic cpuWaitDone(input string name, input int exp_waits);
    int  waits = 0;
    bit  done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (!waitrequest) done = 1'b1;
      else waits++;
      @(posedge clk);
      #1;
    end
    read  = 1'b0;
    write = 1'b0;
    checkOutput(name, waits, exp_waits);
  endtask

  task automatic cpuWrite(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] be);
    for (int i = 0; i < 4; i++)
      if (be[i]) mem_model[addr][8*i +: 8] = data[8*i +: 8];
    address = addr; writedata = data; byteenable = be; write = 1'b1;
    cpuWaitDone("cpu_wr_wait", 0);
  endtask

  task automatic cpuRead(input logic [7:0] addr);
    cpu_exp.push_back(mem_model[addr]);
    address = addr; read = 1'b1;
    cpuWaitDone("cpu_rd_wait", 1);
  endtask

  task automatic checkMonA(input string name);
    checkOutput(name, {24'b0, MonAReg}, {24'b0, mon_a});
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    jdo = '0; take_action_ocimem_a = 1'b0; take_no_action_ocimem_a = 1'b0; take_action_ocimem_b = 1'b0;
    address = '0; read = 1'b0; write = 1'b0; writedata = '0; byteenable = '0;
    repeat (3) step();
    reset_n = 1'b1;
    step();
    $display("[TB] reset values");
    checkOutput("rst_MonDReg", MonDReg, 32'h0);
    checkOutput("rst_MonAReg", {24'b0, MonAReg}, 32'h0);
    checkOutput("rst_readdata", readdata, 32'h0);
    checkOutput("rst_waitrequest", {31'b0, waitrequest}, 32'h0);
    checkOutput("rst_overrun", {31'b0, jtag_overrun}, 32'h0);

    for (int i = 0; i < 256; i++) cpuWrite(8'(i), $urandom, 4'hF);

    $display("[TB] JTAG write then JTAG read at 0x10");
    jtagLoad(8'h10, 1'b0);
    jtagWrite(32'hDEADBEEF);
    checkOutput("jwr_MonAReg", {24'b0, MonAReg}, AUTOINC ? 32'h11 : 32'h10);
    jtagLoad(8'h10, 1'b1);
    checkOutput("jrd_MonAReg", {24'b0, MonAReg}, 32'h10);

    $display("[TB] CPU byte-enabled write over a zeroed word");
    jtagLoad(8'h20, 1'b0);
    jtagWrite(32'h0);
    cpuWrite(8'h20, 32'h12345678, 4'b0011);
    cpuRead(8'h20);
    checkOutput("cpu_be_model", mem_model[8'h20], 32'h00005678);

    $display("[TB] CPU read held off by a JTAG write");
    jtagLoad(8'h30, 1'b0);
    d = $urandom;
    applyStimulus(1'b0, 1'b0, 1'b1, jdoData(d));
    mem_model[mon_a] = d;
    if (AUTOINC) mon_a = mon_a + 8'd1;
    cpu_exp.push_back(d);
    address = 8'h30; read = 1'b1;
    cpuWaitDone("held_rd_wait", 3);
    checkMonA("held_MonAReg");
    checkOutput("pre_overrun", {31'b0, jtag_overrun}, 32'h0);

    $display("[TB] two JTAG writes during a CPU read");
    jtagLoad(8'h40, 1'b0);
    d1 = $urandom; d2 = $urandom;
    cpu_exp.push_back(mem_model[8'h50]);
    address = 8'h50; read = 1'b1;
    take_action_ocimem_b = 1'b1; jdo = jdoData(d1);
    step();
    jdo = jdoData(d2);
    step();
    read = 1'b0; take_action_ocimem_b = 1'b0;
    mem_model[mon_a] = d2;
    if (AUTOINC) mon_a = mon_a + 8'd1;
    repeat (4) step();
    checkOutput("overrun_set", {31'b0, jtag_overrun}, 32'h1);
    checkMonA("overrun_MonAReg");
    cpuRead(8'h40);
    cpuRead(8'h41);

    $display("[TB] randomized traffic");
    for (int k = 0; k < 60; k++) begin
      a = 8'($urandom);
      d = $urandom;
      case ($urandom_range(0, 4))
        0: begin jtagLoad(a, 1'b0); jtagWrite(d); end
        1: jtagLoad(a, 1'b1);
        2: jtagStream();
        3: cpuWrite(a, d, 4'($urandom));
        default: cpuRead(a);
      endcase
      checkMonA("rand_MonAReg");
    end
    checkOutput("overrun_sticky", {31'b0, jtag_overrun}, 32'h1);

    $display("[TB] streaming read at the top address");
    jtagLoad(8'hFF, 1'b0);
    jtagStream();
    checkOutput("wrap_MonAReg", {24'b0, MonAReg}, AUTOINC ? 32'h00 : 32'hFF);

    $display("[TB] reset during a JTAG read");
    applyStimulus(1'b1, 1'b0, 1'b0, jdoLoad(8'h05, 1'b1));
    step();
    reset_n = 1'b0;
    #1;
    checkOutput("mid_MonDReg", MonDReg, 32'h0);
    checkOutput("mid_MonAReg", {24'b0, MonAReg}, 32'h0);
    checkOutput("mid_readdata", readdata, 32'h0);
    checkOutput("mid_waitrequest", {31'b0, waitrequest}, 32'h0);
    checkOutput("mid_overrun", {31'b0, jtag_overrun}, 32'h0);
    step();
    reset_n = 1'b1;
    mon_a = 8'h00;
    repeat (4) step();
    checkOutput("post_MonDReg", MonDReg, 32'h0);
    jtagLoad(8'h10, 1'b1);
    cpuRead(8'h10);

    repeat (2) step();
    checkOutput("cpu_queue_left", cpu_exp.size(), 32'd0);
    checkOutput("jtag_queue_left", jtag_exp.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
